// File: rtl/mem_initiator_pkg.sv
// Shared definitions for the memory bus initiator and the ROM/RAM wrappers.
// Holds the FSM state encoding and the default bus widths used on the
// shared 16-bit-address / 8-bit-data memory bus.
package mem_initiator_pkg;

    // Default bus widths; the memory wrappers size their ports from these.
    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 8;

    // Latency counter width; covers READ_LATENCY 1..7 without wrapping.
    localparam int LAT_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // True once the access has been held for the full read latency.
    function automatic logic lat_done(input logic [LAT_CNT_W-1:0] cnt,
                                      input logic [LAT_CNT_W-1:0] last);
        return cnt == last;
    endfunction

endpackage

// File: rtl/mem_initiator.sv
// Memory bus initiator: accepts one read/write request at a time from the
// core, drives ena/addr/we/dout onto the shared memory bus, holds a read for
// READ_LATENCY+1 cycles, captures bus_din and returns it on the response
// channel. Writes produce no response.
//
// Optional build macro MEM_INITIATOR_WAIT_EN adds a bus_wait input that
// stretches the ACCESS phase (reads and writes) while it is high.
//
// All outputs are registers or decodes of the state register, so there is no
// combinational path from req_* / rsp_ready to any output.
module mem_initiator
    import mem_initiator_pkg::*;
#(
    parameter int ADDR_W       = BUS_ADDR_W,
    parameter int DATA_W       = BUS_DATA_W,
    parameter int READ_LATENCY = 1
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
`ifdef MEM_INITIATOR_WAIT_EN
    input  logic              bus_wait,
`endif
    output logic              bus_ena,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_dout,
    input  logic [DATA_W-1:0] bus_din
);

    // Counter value at which bus_din is valid and gets captured.
    localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(READ_LATENCY);

    state_e               state, state_nxt;
    logic [LAT_CNT_W-1:0] cnt, cnt_nxt;
    logic                 we_q;
    logic                 accept;
    logic                 capture;
    logic                 stall;

`ifdef MEM_INITIATOR_WAIT_EN
    assign stall = bus_wait;
`else
    assign stall = 1'b0;
`endif

    // Outputs decoded from the state register only.
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign bus_ena   = (state == ACCESS);
    assign bus_we    = (state == ACCESS) && we_q;

    // Next-state, counter and strobe decode; defaults hold everything.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                // A stalled access keeps ena/addr/we/dout and the counter frozen.
                if (!stall) begin
                    if (we_q) begin
                        state_nxt = IDLE;
                    end else if (lat_done(cnt, LAT_LAST)) begin
                        capture   = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            RESP: begin
                // Return to IDLE only; a new request waits for the next cycle.
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset abandons any access or pending response.
    always_ff @(posedge clka) begin
        if (rsta) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Request latch drives the bus directly; read data captured at the
    // end of the latency window (unmapped addresses pass through as-is).
    always_ff @(posedge clka) begin
        if (rsta) begin
            we_q      <= 1'b0;
            bus_addr  <= '0;
            bus_dout  <= '0;
            rsp_rdata <= '0;
        end else begin
            if (accept) begin
                we_q     <= req_we;
                bus_addr <= req_addr;
                bus_dout <= req_wdata;
            end
            if (capture) begin
                rsp_rdata <= bus_din;
            end
        end
    end

endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator: two instances (READ_LATENCY 1 and 3), each with a
// ROM (0x0000-0x0FFF) / RAM (0x1000-0x1FFF) responder whose read data is
// only valid after the configured number of edges of stable ena+addr.
// Expected bus activity and response timing come from the transaction rules;
// expected read data come from a reference memory kept by the stimulus.
`timescale 1ns/1ps
module tb_mem_initiator;

    logic        clka = 1'b0;
    logic        rsta      [2];
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [15:0] req_addr  [2];
    logic [7:0]  req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [7:0]  rsp_rdata [2];
    logic        bus_ena   [2];
    logic        bus_we    [2];
    logic [15:0] bus_addr  [2];
    logic [7:0]  bus_dout  [2];
    logic [7:0]  bus_din   [2];
`ifdef MEM_INITIATOR_WAIT_EN
    logic        bus_wait  [2];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clka = ~clka;

    mem_initiator #(.ADDR_W(16), .DATA_W(8), .READ_LATENCY(1)) u_dut1 (
        .clka(clka), .rsta(rsta[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
`ifdef MEM_INITIATOR_WAIT_EN
        .bus_wait(bus_wait[0]),
`endif
        .bus_ena(bus_ena[0]), .bus_we(bus_we[0]), .bus_addr(bus_addr[0]),
        .bus_dout(bus_dout[0]), .bus_din(bus_din[0])
    );

    mem_initiator #(.ADDR_W(16), .DATA_W(8), .READ_LATENCY(3)) u_dut3 (
        .clka(clka), .rsta(rsta[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
`ifdef MEM_INITIATOR_WAIT_EN
        .bus_wait(bus_wait[1]),
`endif
        .bus_ena(bus_ena[1]), .bus_we(bus_we[1]), .bus_addr(bus_addr[1]),
        .bus_dout(bus_dout[1]), .bus_din(bus_din[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [7:0] rom_val(input logic [15:0] a);
        return (a == 16'h0123) ? 8'hA5 : (a[7:0] ^ 8'h3C);
    endfunction

    // ---------------- responders ----------------
    logic [7:0]  bus_ram [2][0:4095];
    logic        run_on  [2];
    logic [15:0] run_addr[2];
    int          run_cnt [2];

    // RAM writes and tracking of how long the current read has been held.
    always @(posedge clka) begin
        for (int d = 0; d < 2; d++) begin
            if (bus_ena[d] && bus_we[d] && bus_addr[d][15:12] == 4'h1)
                bus_ram[d][bus_addr[d][11:0]] <= bus_dout[d];
            if (bus_ena[d] && !bus_we[d]) begin
                run_cnt[d]  <= (run_on[d] && run_addr[d] == bus_addr[d]) ? run_cnt[d] + 1 : 1;
                run_on[d]   <= 1'b1;
                run_addr[d] <= bus_addr[d];
            end else begin
                run_on[d]  <= 1'b0;
                run_cnt[d] <= 0;
            end
        end
    end

    // Read data only valid after the latency has elapsed; junk otherwise,
    // unmapped space reads as a pulled-up 0xFF.
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            bus_din[d] = 8'h99;
            if (bus_ena[d] && !bus_we[d] && run_on[d] && run_addr[d] == bus_addr[d] &&
                run_cnt[d] >= lat_of(d)) begin
                if (bus_addr[d][15:12] == 4'h0)      bus_din[d] = rom_val(bus_addr[d]);
                else if (bus_addr[d][15:12] == 4'h1) bus_din[d] = bus_ram[d][bus_addr[d][11:0]];
                else                                 bus_din[d] = 8'hFF;
            end
        end
    end

    // ---------------- reference memory ----------------
    logic [7:0] exp_ram [2][0:4095];
    bit         ram_ok  [2][16];

    function automatic logic [7:0] ref_rd(input int d, input logic [15:0] a);
        if (a[15:12] == 4'h0) return rom_val(a);
        if (a[15:12] == 4'h1) return exp_ram[d][a[11:0]];
        return 8'hFF;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, d, act, exp, $time);
        end
    endtask

    // Junk on the request port while busy: must be neither accepted nor used.
    task automatic scramble(input int d);
        req_valid[d] = 1'b1;
        req_we[d]    = 1'($urandom_range(0, 1));
        req_addr[d]  = 16'($urandom);
        req_wdata[d] = 8'($urandom);
    endtask

    // One complete transaction; called and returns at a negedge with DUT idle.
    task automatic access(input int d, input logic we, input logic [15:0] addr,
                          input logic [7:0] wdata, input logic [7:0] exp_rd,
                          input int hold, input int nwait);
        int n_acc;
        n_acc = (we ? 1 : lat_of(d) + 1) + nwait;
        chk("req_ready_idle", d, req_ready[d], 1);
        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata;
        for (int k = 1; k <= n_acc; k++) begin
            @(negedge clka);
            scramble(d);
            rsp_ready[d] = 1'($urandom_range(0, 1));
`ifdef MEM_INITIATOR_WAIT_EN
            bus_wait[d] = (k <= nwait);
`endif
            chk("bus_ena", d, bus_ena[d], 1);
            chk("bus_we", d, bus_we[d], we);
            chk("bus_addr", d, bus_addr[d], addr);
            if (we) chk("bus_dout", d, bus_dout[d], wdata);
            chk("req_ready_busy", d, req_ready[d], 0);
            chk("rsp_valid_busy", d, rsp_valid[d], 0);
        end
`ifdef MEM_INITIATOR_WAIT_EN
        bus_wait[d] = 1'b0;
`endif
        if (we) begin
            if (addr[15:12] == 4'h1) exp_ram[d][addr[11:0]] = wdata;
            @(negedge clka);
            chk("wr_bus_ena_end", d, bus_ena[d], 0);
            chk("wr_req_ready_end", d, req_ready[d], 1);
            chk("wr_no_rsp", d, rsp_valid[d], 0);
        end else begin
            @(negedge clka);
            chk("rsp_valid", d, rsp_valid[d], 1);
            chk("rsp_rdata", d, rsp_rdata[d], exp_rd);
            chk("resp_bus_ena", d, bus_ena[d], 0);
            chk("resp_req_ready", d, req_ready[d], 0);
            rsp_ready[d] = (hold == 0);
            for (int h = 1; h <= hold; h++) begin
                @(negedge clka);
                chk("bp_rsp_valid", d, rsp_valid[d], 1);
                chk("bp_rsp_rdata", d, rsp_rdata[d], exp_rd);
                chk("bp_bus_ena", d, bus_ena[d], 0);
                chk("bp_req_ready", d, req_ready[d], 0);
                rsp_ready[d] = (h == hold);
            end
            @(negedge clka);
            chk("rsp_done_valid", d, rsp_valid[d], 0);
            chk("rsp_done_ready", d, req_ready[d], 1);
            chk("no_bypass_ena", d, bus_ena[d], 0);
        end
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b0;
    endtask

    typedef struct {
        int         d;
        logic       we;
        logic [15:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
        int         hold;
        int         nwait;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{0, 1'b0, 16'h0123, 8'h00, 8'hA5, 0, 0});
        vecs.push_back('{0, 1'b1, 16'h1040, 8'h5A, 8'h00, 0, 0});
        vecs.push_back('{0, 1'b0, 16'h1040, 8'h00, 8'h5A, 0, 0});
        vecs.push_back('{0, 1'b0, 16'h0123, 8'h00, 8'hA5, 4, 0});
        vecs.push_back('{0, 1'b1, 16'h0123, 8'hFF, 8'h00, 0, 0});
        vecs.push_back('{0, 1'b0, 16'h0123, 8'h00, 8'hA5, 1, 0});
        vecs.push_back('{0, 1'b0, 16'h8000, 8'h00, 8'hFF, 0, 0});
        vecs.push_back('{1, 1'b0, 16'h0123, 8'h00, 8'hA5, 2, 0});
        vecs.push_back('{1, 1'b1, 16'h1FFF, 8'h81, 8'h00, 0, 0});
        vecs.push_back('{1, 1'b0, 16'h1FFF, 8'h00, 8'h81, 0, 0});
        vecs.push_back('{1, 1'b0, 16'h0FFF, 8'h00, 8'hC3, 3, 0});
`ifdef MEM_INITIATOR_WAIT_EN
        vecs.push_back('{0, 1'b0, 16'h0010, 8'h00, 8'h2C, 0, 3});
        vecs.push_back('{1, 1'b1, 16'h1003, 8'h77, 8'h00, 0, 2});
        vecs.push_back('{1, 1'b0, 16'h1003, 8'h00, 8'h77, 1, 1});
`endif

        for (int d = 0; d < 2; d++) begin
            rsta[d] = 1'b1; req_valid[d] = 1'b1; req_we[d] = 1'b1;
            req_addr[d] = 16'h1234; req_wdata[d] = 8'h55; rsp_ready[d] = 1'b0;
`ifdef MEM_INITIATOR_WAIT_EN
            bus_wait[d] = 1'b0;
`endif
        end

        // Reset held 3 cycles with a request pending.
        for (int c = 0; c < 3; c++) begin
            @(negedge clka);
            for (int d = 0; d < 2; d++) begin
                chk("rst_req_ready", d, req_ready[d], 1);
                chk("rst_rsp_valid", d, rsp_valid[d], 0);
                chk("rst_rsp_rdata", d, rsp_rdata[d], 0);
                chk("rst_bus_ena", d, bus_ena[d], 0);
                chk("rst_bus_we", d, bus_we[d], 0);
                chk("rst_bus_addr", d, bus_addr[d], 0);
                chk("rst_bus_dout", d, bus_dout[d], 0);
            end
        end
        for (int d = 0; d < 2; d++) begin rsta[d] = 1'b0; req_valid[d] = 1'b0; end
        @(negedge clka);
        for (int d = 0; d < 2; d++) begin
            chk("post_rst_ready", d, req_ready[d], 1);
            chk("post_rst_ena", d, bus_ena[d], 0);
        end

        // Directed vectors.
        foreach (vecs[i])
            access(vecs[i].d, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rd, vecs[i].hold, vecs[i].nwait);

        // Reset in the 2nd ACCESS cycle of a READ_LATENCY=3 read.
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 16'h0123;
        @(negedge clka);
        req_valid[1] = 1'b0;
        chk("mid_acc1_ena", 1, bus_ena[1], 1);
        @(negedge clka);
        chk("mid_acc2_ena", 1, bus_ena[1], 1);
        rsta[1] = 1'b1;
        @(negedge clka);
        chk("mid_rst_ena", 1, bus_ena[1], 0);
        chk("mid_rst_valid", 1, rsp_valid[1], 0);
        chk("mid_rst_ready", 1, req_ready[1], 1);
        chk("mid_rst_addr", 1, bus_addr[1], 0);
        rsta[1] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clka);
            chk("mid_no_rsp", 1, rsp_valid[1], 0);
            chk("mid_no_ena", 1, bus_ena[1], 0);
        end

        // Reset while a response is pending discards it.
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 16'h0042;
        @(negedge clka);
        req_valid[0] = 1'b0;
        @(negedge clka);
        @(negedge clka);
        chk("resp_pend_valid", 0, rsp_valid[0], 1);
        chk("resp_pend_rdata", 0, rsp_rdata[0], rom_val(16'h0042));
        rsta[0] = 1'b1;
        @(negedge clka);
        chk("resp_rst_valid", 0, rsp_valid[0], 0);
        chk("resp_rst_rdata", 0, rsp_rdata[0], 0);
        rsta[0] = 1'b0;
        @(negedge clka);
        chk("resp_rst_ready", 0, req_ready[0], 1);
        chk("resp_rst_no_rsp", 0, rsp_valid[0], 0);

        // Randomized traffic against the reference memory.
        for (int i = 0; i < 80; i++) begin
            int d, kind, nw, hold;
            logic we;
            logic [15:0] a;
            logic [7:0] wd;
            d    = $urandom_range(0, 1);
            kind = $urandom_range(0, 3);
            wd   = 8'($urandom);
            hold = $urandom_range(0, 3);
            nw   = 0;
`ifdef MEM_INITIATOR_WAIT_EN
            nw   = $urandom_range(0, 3);
`endif
            case (kind)
                0: begin we = 1'b0; a = 16'($urandom_range(0, 16'h0FFF)); end
                1: begin
                    we = 1'b1; a = 16'h1000 + 16'($urandom_range(0, 15));
                    ram_ok[d][a[3:0]] = 1'b1;
                end
                2: begin
                    we = 1'b0; a = 16'h1000 + 16'($urandom_range(0, 15));
                    if (!ram_ok[d][a[3:0]]) a = 16'($urandom_range(0, 16'h0FFF));
                end
                default: begin
                    we = 1'($urandom_range(0, 1)); a = 16'h2000 + 16'($urandom_range(0, 16'hDFFF));
                end
            endcase
            access(d, we, a, wd, ref_rd(d, a), hold, nw);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
